// File: rtl/ahb_stream_writer.sv
// AHB-Lite write master that drains a 32-bit valid/ready stream into a
// contiguous, word-aligned RAM region using single NONSEQ word writes.
// Words are buffered in a small FIFO; the bus side is fully pipelined
// (address phase of word n+1 overlaps the data phase of word n).
module ahb_stream_writer #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int          WORDS      = 256
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    // Index must hold WORDS itself (up to 2**16), hence 17 bits.
    localparam int IW = 17;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] WORDS_C = IW'(WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // FIFO storage and bookkeeping
    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    // Bus-side registers
    logic          htrans_q;   // 1 = NONSEQ presented in the address phase
    logic          dphase;     // a data phase is in progress this cycle
    logic [31:0]   haddr_q;
    logic [31:0]   hwdata_q;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic [31:0]   next_addr;

    logic start_acc;
    logic push;
    logic accept;
    logic err_first;
    logic cancel;
    logic pop;
    logic issue;
    logic last_done;

    assign s_ready   = (count != DEPTH_C);
    assign start_acc = start && (state == S_IDLE);
    // A push coinciding with an accepted start is dropped by the flush.
    assign push      = s_valid && s_ready && !start_acc;
    assign accept    = (state == S_RUN) && htrans_q && HREADY;
    // First cycle of the two-cycle ERROR response.
    assign err_first = (state == S_RUN) && dphase && HRESP && !HREADY;
    // The address phase still pending when ERROR arrives is dropped with its word.
    assign cancel    = err_first && htrans_q;
    assign pop       = accept || cancel;
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign idx_nxt   = idx + IW'(accept);
    assign next_addr = BASE_ADDR + (32'(idx_nxt) << 2);
    assign issue     = (count_nxt != '0) && (idx_nxt < WORDS_C);
    assign last_done = (state == S_RUN) && dphase && HREADY && !HRESP && (idx == WORDS_C);

    assign HTRANS = {htrans_q, 1'b0};
    assign HWRITE = htrans_q;
    assign HADDR  = haddr_q;
    assign HWDATA = hwdata_q;
    assign HSIZE  = 3'b010;

    // Control state register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection: job start, normal completion, error unwind.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (err_first) begin
                    state_nxt = S_ERR;
                end else if (last_done) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERR: if (HREADY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Busy covers the whole job, including the second ERROR cycle.
    always_comb begin
        busy = (state != S_IDLE);
    end

    // FIFO pointers and occupancy; an accepted start empties the buffer.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (start_acc) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    // FIFO word storage (no reset needed, occupancy guards reads).
    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    // Bus address/data phase registers, word index and status flags.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            htrans_q <= 1'b0;
            dphase   <= 1'b0;
            haddr_q  <= BASE_ADDR;
            hwdata_q <= '0;
            idx      <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done <= last_done;

            if (start_acc) begin
                error <= 1'b0;
            end else if ((state == S_ERR) && HREADY) begin
                error <= 1'b1;
            end

            if (start_acc) begin
                idx <= '0;
            end else if (accept) begin
                idx <= idx_nxt;
            end

            if (accept) hwdata_q <= mem[rd_ptr];

            // Address/control only move when the bus is ready, except that
            // an ERROR response must withdraw a pending NONSEQ immediately.
            if (err_first) begin
                htrans_q <= 1'b0;
            end else if ((state == S_RUN) && HREADY) begin
                htrans_q <= issue;
                dphase   <= accept;
                if (issue) haddr_q <= next_addr;
            end

            if (state != S_RUN) dphase <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb_stream_writer.sv
// Directed testbench for ahb_stream_writer (WORDS=4, FIFO_DEPTH=4).
// A passive logger records every completed OKAY write as (address, data).
module tb_ahb_stream_writer;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        start;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    ahb_stream_writer #(
        .FIFO_DEPTH(4),
        .BASE_ADDR (BASE),
        .WORDS     (4)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .start  (start),
        .s_valid(s_valid),
        .s_data (s_data),
        .s_ready(s_ready),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .HADDR  (HADDR),
        .HTRANS (HTRANS),
        .HWRITE (HWRITE),
        .HSIZE  (HSIZE),
        .HWDATA (HWDATA),
        .HREADY (HREADY),
        .HRESP  (HRESP)
    );

    always #5 HCLK = ~HCLK;

    // Write logger: behaves like the RAM slave's view of completed writes.
    logic        dp_pend;
    logic [31:0] dp_addr;
    logic [31:0] log_addr [0:63];
    logic [31:0] log_data [0:63];
    int          nlog = 0;

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_pend <= 1'b0;
        end else begin
            if (dp_pend && HREADY && !HRESP && nlog < 64) begin
                log_addr[nlog] <= dp_addr;
                log_data[nlog] <= HWDATA;
                nlog <= nlog + 1;
            end
            if (HREADY) begin
                dp_pend <= (HTRANS == 2'b10);
                dp_addr <= HADDR;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int base,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3);
        logic [31:0] exp_d [4];
        exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
        chk({tag, "_nwrites"}, 32'(nlog - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), log_addr[base + i], BASE + 32'(4 * i));
            chk($sformatf("%s_data%0d", tag, i), log_data[base + i], exp_d[i]);
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge HCLK);
            if (done === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        int  nons;
        int  dones;
        bit  rdy_ok;

        HRESET = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) @(negedge HCLK);

        // ---- reset values
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_haddr",  HADDR, BASE);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_hsize",  32'(HSIZE), 32'd2);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_error",  32'(error), 32'd0);
        chk("rst_sready", 32'(s_ready), 32'd1);
        HRESET = 1'b0;
        @(negedge HCLK);

        // ---- job 1: zero wait states, back-to-back writes
        base = nlog;
        start = 1'b1;
        @(negedge HCLK); start = 1'b0;
        chk("j1_busy", 32'(busy), 32'd1);
        s_valid = 1'b1; s_data = 32'h11;
        @(negedge HCLK);
        chk("j1_htrans0", 32'(HTRANS), 32'd2);
        chk("j1_haddr0",  HADDR, BASE);
        chk("j1_hwrite0", 32'(HWRITE), 32'd1);
        s_data = 32'h22;
        @(negedge HCLK);
        chk("j1_haddr1",  HADDR, BASE + 32'h4);
        chk("j1_hwdata0", HWDATA, 32'h11);
        s_data = 32'h33;
        @(negedge HCLK);
        chk("j1_haddr2",  HADDR, BASE + 32'h8);
        chk("j1_hwdata1", HWDATA, 32'h22);
        s_data = 32'h44;
        @(negedge HCLK);
        chk("j1_haddr3",  HADDR, BASE + 32'hC);
        chk("j1_hwdata2", HWDATA, 32'h33);
        s_valid = 1'b0;
        @(negedge HCLK);
        chk("j1_htrans_end", 32'(HTRANS), 32'd0);
        chk("j1_hwdata3",    HWDATA, 32'h44);
        chk("j1_done_early", 32'(done), 32'd0);
        chk("j1_busy_last",  32'(busy), 32'd1);
        @(negedge HCLK);
        chk("j1_done",      32'(done), 32'd1);
        chk("j1_busy_done", 32'(busy), 32'd0);
        @(negedge HCLK);
        chk("j1_done_pulse", 32'(done), 32'd0);
        check_log("j1", base, 32'h11, 32'h22, 32'h33, 32'h44);

        // ---- job 2: two wait states in the second data phase
        base = nlog;
        start = 1'b1;
        @(negedge HCLK); start = 1'b0; s_valid = 1'b1; s_data = 32'h11;
        @(negedge HCLK); s_data = 32'h22;
        @(negedge HCLK); s_data = 32'h33;
        @(negedge HCLK);
        chk("j2_haddr_w0",  HADDR, BASE + 32'h8);
        chk("j2_hwdata_w0", HWDATA, 32'h22);
        HREADY = 1'b0; s_data = 32'h44;
        @(negedge HCLK);
        s_valid = 1'b0;
        chk("j2_haddr_w1",  HADDR, BASE + 32'h8);
        chk("j2_hwdata_w1", HWDATA, 32'h22);
        chk("j2_htrans_w1", 32'(HTRANS), 32'd2);
        @(negedge HCLK);
        chk("j2_haddr_w2",  HADDR, BASE + 32'h8);
        chk("j2_hwdata_w2", HWDATA, 32'h22);
        HREADY = 1'b1;
        @(negedge HCLK);
        chk("j2_haddr3",  HADDR, BASE + 32'hC);
        chk("j2_hwdata2", HWDATA, 32'h33);
        @(negedge HCLK);
        chk("j2_htrans_end", 32'(HTRANS), 32'd0);
        chk("j2_hwdata3",    HWDATA, 32'h44);
        @(negedge HCLK);
        chk("j2_done", 32'(done), 32'd1);
        check_log("j2", base, 32'h11, 32'h22, 32'h33, 32'h44);

        // ---- job 3: stream trickles one word every three cycles
        base = nlog; nons = 0; dones = 0; rdy_ok = 1'b1;
        start = 1'b1;
        @(negedge HCLK); start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (HTRANS == 2'b10) nons++;
            if (done) dones++;
            if (!s_ready) rdy_ok = 1'b0;
            if (i == 2) chk("j3_idle_gap", 32'(HTRANS), 32'd0);
            s_valid = ((i % 3) == 0) && (i < 12);
            s_data  = 32'hA0 + 32'(i);
            @(negedge HCLK);
        end
        s_valid = 1'b0;
        chk("j3_nonseq_count", 32'(nons), 32'd4);
        chk("j3_done_count",   32'(dones), 32'd1);
        chk("j3_sready_high",  32'(rdy_ok), 32'd1);
        check_log("j3", base, 32'hA0, 32'hA3, 32'hA6, 32'hA9);

        // ---- job 4: fill the FIFO while the bus is stalled
        base = nlog;
        start = 1'b1;
        @(negedge HCLK); start = 1'b0; HREADY = 1'b0; s_valid = 1'b1; s_data = 32'hB0;
        @(negedge HCLK); s_data = 32'hB1;
        @(negedge HCLK); s_data = 32'hB2;
        @(negedge HCLK); s_data = 32'hB3;
        @(negedge HCLK);
        chk("j4_full_sready",  32'(s_ready), 32'd0);
        chk("j4_stall_htrans", 32'(HTRANS), 32'd0);
        s_data = 32'hB4;
        @(negedge HCLK);
        chk("j4_full_hold", 32'(s_ready), 32'd0);
        s_valid = 1'b0; HREADY = 1'b1;
        @(negedge HCLK);
        chk("j4_htrans0", 32'(HTRANS), 32'd2);
        chk("j4_haddr0",  HADDR, BASE);
        @(negedge HCLK);
        chk("j4_sready_after", 32'(s_ready), 32'd1);
        chk("j4_hwdata0",      HWDATA, 32'hB0);
        wait_done("j4_done");
        check_log("j4", base, 32'hB0, 32'hB1, 32'hB2, 32'hB3);

        // ---- job 5: ERROR response on the third write
        base = nlog;
        start = 1'b1;
        @(negedge HCLK); start = 1'b0; s_valid = 1'b1; s_data = 32'hC0;
        @(negedge HCLK); s_data = 32'hC1;
        @(negedge HCLK); s_data = 32'hC2;
        @(negedge HCLK); s_data = 32'hC3;
        @(negedge HCLK);
        s_valid = 1'b0;
        chk("j5_pending_htrans", 32'(HTRANS), 32'd2);
        chk("j5_pending_haddr",  HADDR, BASE + 32'hC);
        chk("j5_err_hwdata",     HWDATA, 32'hC2);
        HREADY = 1'b0; HRESP = 1'b1;
        @(negedge HCLK);
        chk("j5_err2_htrans", 32'(HTRANS), 32'd0);
        chk("j5_err2_busy",   32'(busy), 32'd1);
        HREADY = 1'b1;
        @(negedge HCLK);
        chk("j5_error_set", 32'(error), 32'd1);
        chk("j5_busy_off",  32'(busy), 32'd0);
        chk("j5_no_done",   32'(done), 32'd0);
        HRESP = 1'b0;
        @(negedge HCLK);
        chk("j5_error_sticky", 32'(error), 32'd1);
        chk("j5_no_done2",     32'(done), 32'd0);
        chk("j5_nwrites",      32'(nlog - base), 32'd2);
        chk("j5_log_data1",    log_data[base + 1], 32'hC1);

        // restart after the error: error clears, writes begin at BASE again
        base = nlog;
        start = 1'b1;
        @(negedge HCLK); start = 1'b0;
        chk("j5r_error_clr", 32'(error), 32'd0);
        chk("j5r_busy",      32'(busy), 32'd1);
        s_valid = 1'b1; s_data = 32'hD0;
        @(negedge HCLK);
        chk("j5r_htrans0", 32'(HTRANS), 32'd2);
        chk("j5r_haddr0",  HADDR, BASE);
        s_data = 32'hD1;
        @(negedge HCLK); s_data = 32'hD2;
        @(negedge HCLK); s_data = 32'hD3;
        @(negedge HCLK); s_valid = 1'b0;
        wait_done("j5r_done");
        check_log("j5r", base, 32'hD0, 32'hD1, 32'hD2, 32'hD3);

        // ---- job 6: start while busy is ignored, then reset mid-job
        start = 1'b1;
        @(negedge HCLK); start = 1'b0; s_valid = 1'b1; s_data = 32'hE0;
        @(negedge HCLK);
        chk("j6_haddr0", HADDR, BASE);
        start = 1'b1; s_data = 32'hE1;
        @(negedge HCLK);
        start = 1'b0; s_valid = 1'b0;
        chk("j6_no_restart_htrans", 32'(HTRANS), 32'd2);
        chk("j6_no_restart_haddr",  HADDR, BASE + 32'h4);
        chk("j6_busy",              32'(busy), 32'd1);
        @(negedge HCLK);
        chk("j6_hwdata1", HWDATA, 32'hE1);
        HRESET = 1'b1;
        #1;
        chk("j6_rst_htrans", 32'(HTRANS), 32'd0);
        chk("j6_rst_haddr",  HADDR, BASE);
        chk("j6_rst_hwdata", HWDATA, 32'd0);
        chk("j6_rst_busy",   32'(busy), 32'd0);
        chk("j6_rst_sready", 32'(s_ready), 32'd1);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("j6_post_busy",   32'(busy), 32'd0);
        chk("j6_post_done",   32'(done), 32'd0);
        chk("j6_post_error",  32'(error), 32'd0);
        chk("j6_post_htrans", 32'(HTRANS), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
